uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 0, meaning idle clocks inserted after each completed character before the next grant (0..255).
REQ-002 SHALL have parameter LO_TIMEOUT, default 16, meaning max clocks to wait for txrdy to fall after load (1..255).
REQ-003 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1 each  requester has a byte to send.
REQ-006 SHALL have ports req0_data / req1_data  input  8 each  byte offered by requester.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1 each  byte accepted this cycle (transfer = valid & ready).
REQ-008 SHALL have port txrdy  input  1  tx_engine ready (high = idle, low = shifting).
REQ-009 SHALL have port load  output  1  one-cycle load strobe to tx_engine.
REQ-010 SHALL have port out_data  output  8  byte presented to tx_engine, registered.
REQ-011 SHALL have port grant  output  1  requester index of the most recent transfer.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port err  output  1  sticky flag: txrdy failed to fall within LO_TIMEOUT.
REQ-014 SHALL have port char_count  output  16  completed characters since reset.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, WAIT_LO, WAIT_HI, GAP.
REQ-016 IDLE: reqN_ready SHALL be combinational = (state==IDLE) & txrdy & (N selected); at most one ready high per cycle.
REQ-017 Selection: single valid wins; both valid -> requester other than grant wins (round-robin); none valid -> no ready.
REQ-018 On transfer: out_data <= selected data, grant <= N, next state LOAD.
REQ-019 LOAD: load SHALL be 1 for exactly this one cycle; out_data stable; next WAIT_LO, timeout counter cleared.
REQ-020 WAIT_LO: txrdy==0 -> WAIT_HI; else counter increments; counter reaching LO_TIMEOUT -> err <= 1, next IDLE, char_count unchanged.
REQ-021 WAIT_HI: txrdy==1 -> char_count += 1 (wraps FFFF->0000); next GAP if GAP_CYCLES>0, else IDLE.
REQ-022 GAP: down-counter loaded with GAP_CYCLES on entry; IDLE after exactly GAP_CYCLES clocks in GAP.
REQ-023 IDLE with txrdy==0 SHALL grant nothing, regardless of valids.
REQ-024 Requester dropping valid before ready: no transfer, no state change, round-robin pointer unchanged.
REQ-025 Requester inputs SHALL be ignored outside IDLE; ready low in all non-IDLE states.
REQ-026 err SHALL be cleared only by reset; err does not block further operation.
REQ-027 Byte-to-load latency: load asserts the cycle after the transfer cycle (1 clock).

Reset
REQ-028 While reset high, on the next edge: state=IDLE, load=0, out_data=8'h00, grant=1 (req0 wins first contention), busy=0, err=0, char_count=0, all counters 0.
REQ-029 Reset mid-character (any non-IDLE state) SHALL abandon the byte; no load pulse issued after the reset edge; ready low while reset high.

Verification
REQ-030 Single: txrdy=1, req0_valid=1 data 8'h41 -> req0_ready same cycle, next cycle load=1 out_data=41; tx model drops txrdy 2 clk, raises 100 clk later -> char_count=1, busy=0.
REQ-031 Contention: both valid continuously (req0=8'hAA, req1=8'h55) for 4 chars -> out_data sequence AA,55,AA,55; grant 0,1,0,1.
REQ-032 Gap: GAP_CYCLES=3, two back-to-back req0 bytes -> exactly 3 clocks between txrdy rising and next req0_ready.
REQ-033 Timeout: LO_TIMEOUT=16, txrdy held 1 after load -> err=1 at 16th WAIT_LO clock, return to IDLE, char_count unchanged; next byte still sent.
REQ-034 Reset in WAIT_HI: assert reset 1 clk -> all outputs at REQ-028 values, no further load until new transfer.
REQ-035 Wrap: preset via 65536 completions (or forced count FFFF) -> next completion gives char_count=0000.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding one UART tx_engine; load strobes 1 clk after the transfer.
// Backpressure: reqN_ready is only offered in IDLE while txrdy is high; all other states ignore requesters.
module uart_tx_arbiter #(
   parameter int unsigned GAP_CYCLES = 0,
   parameter int unsigned LO_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic        req1_valid,
   input  logic [7:0]  req0_data,
   input  logic [7:0]  req1_data,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic        txrdy,
   output logic        load,
   output logic [7:0]  out_data,
   output logic        grant,
   output logic        busy,
   output logic        err,
   output logic [15:0] char_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_LO,
      S_WAIT_HI,
      S_GAP
   } state_t;

   localparam logic [7:0] GAP_INIT = 8'(GAP_CYCLES);
   localparam logic [7:0] LO_LIMIT = 8'(LO_TIMEOUT);

   state_t      state_q, state_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        grant_q, grant_d;
   logic        err_q, err_d;
   logic [15:0] char_count_q, char_count_d;
   logic [7:0]  to_cnt_q, to_cnt_d;
   logic [7:0]  gap_cnt_q, gap_cnt_d;
   logic        sel1;
   logic        take;

   // On contention the requester that did not win last time goes first.
   always_comb begin
      if (req0_valid && req1_valid) begin
         sel1 = ~grant_q;
      end else begin
         sel1 = req1_valid;
      end
   end

   assign take       = (state_q == S_IDLE) & txrdy & (req0_valid | req1_valid) & ~reset;
   assign req0_ready = take & ~sel1;
   assign req1_ready = take & sel1;

   always_comb begin
      state_d      = state_q;
      out_data_d   = out_data_q;
      grant_d      = grant_q;
      err_d        = err_q;
      char_count_d = char_count_q;
      to_cnt_d     = to_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (take) begin
               out_data_d = sel1 ? req1_data : req0_data;
               grant_d    = sel1;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            to_cnt_d = '0;
            state_d  = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            if (!txrdy) begin
               state_d = S_WAIT_HI;
            end else begin
               to_cnt_d = to_cnt_q + 8'd1;
               // Engine never started: flag it and give up on this byte.
               if (to_cnt_d == LO_LIMIT) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_WAIT_HI: begin
            if (txrdy) begin
               char_count_d = char_count_q + 16'd1;
               if (GAP_CYCLES != 0) begin
                  gap_cnt_d = GAP_INIT;
                  state_d   = S_GAP;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt_q <= 8'd1) begin
               gap_cnt_d = '0;
               state_d   = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         out_data_q   <= 8'h00;
         grant_q      <= 1'b1;
         err_q        <= 1'b0;
         char_count_q <= 16'h0000;
         to_cnt_q     <= 8'h00;
         gap_cnt_q    <= 8'h00;
      end else begin
         state_q      <= state_d;
         out_data_q   <= out_data_d;
         grant_q      <= grant_d;
         err_q        <= err_d;
         char_count_q <= char_count_d;
         to_cnt_q     <= to_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

   assign load       = (state_q == S_LOAD);
   assign busy       = (state_q != S_IDLE);
   assign out_data   = out_data_q;
   assign grant      = grant_q;
   assign err        = err_q;
   assign char_count = char_count_q;

endmodule
